// File: rtl/heartbeat_monitor.sv
// Heartbeat monitor: synchronises a slow toggling input, measures its half-period,
// checks it against a legal window and flags loss of the heartbeat.
module heartbeat_monitor #(
  parameter logic [23:0] HALF_MIN = 24'd8000000,
  parameter logic [23:0] HALF_MAX = 24'd8800000,
  parameter logic [23:0] TIMEOUT  = 24'd12000000
) (
  input  logic        clk_input,
  input  logic        rst,
  input  logic        hb_in,
  input  logic        enable,
  input  logic        clr_err,
  output logic        alive,
  output logic        fault,
  output logic        range_err,
  output logic [23:0] half_period,
  output logic        period_valid,
  output logic [15:0] edge_count
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned EC_W   = 16;
  localparam int unsigned GOOD_W = 2;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOST} state_t;

  state_t              state, state_n;
  logic [SYNC_W-1:0]   sync;
  logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc, meas;
  logic [GOOD_W-1:0]   good, good_n, good_inc;
  logic                alive_n, fault_n, range_err_n, period_valid_n;
  logic [CNT_W-1:0]    half_period_n;
  logic [EC_W-1:0]     edge_count_n;
  logic                edge_det, in_range, timeout_hit;

  // Synchroniser plus history flop; runs regardless of enable so no stale edge appears on re-enable
  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_W-2:0], hb_in};
  end

  assign edge_det    = sync[1] ^ sync[2];
  assign cnt_inc     = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  assign meas        = cnt + CNT_W'(1);
  assign in_range    = (meas >= HALF_MIN) && (meas <= HALF_MAX);
  assign timeout_hit = (cnt == TIMEOUT - CNT_W'(1));
  assign good_inc    = (good == {GOOD_W{1'b1}}) ? good : good + GOOD_W'(1);

  always_ff @(posedge clk_input or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      good         <= '0;
      alive        <= 1'b0;
      fault        <= 1'b0;
      range_err    <= 1'b0;
      half_period  <= '0;
      period_valid <= 1'b0;
      edge_count   <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      good         <= good_n;
      alive        <= alive_n;
      fault        <= fault_n;
      range_err    <= range_err_n;
      half_period  <= half_period_n;
      period_valid <= period_valid_n;
      edge_count   <= edge_count_n;
    end
  end

  // Next-state and datapath; sticky flags clear on clr_err unless set this same cycle
  always_comb begin
    state_n        = state;
    cnt_n          = cnt_inc;
    good_n         = good;
    alive_n        = alive;
    fault_n        = fault & ~clr_err;
    range_err_n    = range_err & ~clr_err;
    half_period_n  = half_period;
    period_valid_n = 1'b0;
    edge_count_n   = edge_count;

    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      good_n  = '0;
      alive_n = 1'b0;
    end else begin
      if (edge_det) begin
        cnt_n        = '0;
        edge_count_n = edge_count + EC_W'(1);
      end
      case (state)
        IDLE: begin
          state_n = ACQUIRE;
          cnt_n   = '0;
        end
        ACQUIRE: begin
          if (edge_det) begin
            state_n = TRACK;
          end else if (timeout_hit) begin
            state_n = LOST;
            fault_n = 1'b1;
            good_n  = '0;
            alive_n = 1'b0;
          end
        end
        TRACK: begin
          if (edge_det) begin
            half_period_n  = meas;
            period_valid_n = 1'b1;
            if (in_range) begin
              good_n  = good_inc;
              alive_n = (good_inc >= GOOD_W'(2));
            end else begin
              range_err_n = 1'b1;
              good_n      = '0;
              alive_n     = 1'b0;
            end
          end else if (timeout_hit) begin
            state_n = LOST;
            fault_n = 1'b1;
            good_n  = '0;
            alive_n = 1'b0;
          end
        end
        LOST: begin
          if (edge_det) state_n = ACQUIRE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
